// File: rtl/xfire_bkm_iter_core.sv
// ============================================================================
// Module   : xfire_bkm_iter_core
// Brief    : Iterative real-valued BKM shift-and-add core, exp (E-mode) and
//            ln (L-mode), one iteration per enabled clock, external ln table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xfire_bkm_iter_core #(
    parameter int W     = 64,
    parameter int F     = 60,
    parameter int N     = 64,
    parameter int LOG2N = 6
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             srst,
    input  logic             enable,
    input  logic             start,
    input  logic             mode,
    input  logic [W-1:0]     x_in,
    output logic [LOG2N-1:0] lut_addr,
    input  logic [W-1:0]     lut_data,
    output logic [W-1:0]     result,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ITER   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam logic [W-1:0]     c_one    = W'(1) << F;
    localparam logic [LOG2N-1:0] c_n_last = LOG2N'(N - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [W-1:0]     r_e;
    logic [W-1:0]     r_l;
    logic [W-1:0]     r_x;
    logic [LOG2N-1:0] r_n;
    logic             r_mode;
    logic             r_err_pend;

    logic [W:0]       w_s;
    logic             w_d;
    logic             w_range_err;

    // ln of a value below 1.0 is negative and not representable
    assign w_range_err = mode && (x_in < c_one);

    // One extra bit so the L-mode compare against x sees any carry out
    assign w_s = {1'b0, r_e} + ({1'b0, r_e} >> r_n);
    assign w_d = r_mode ? (w_s <= {1'b0, r_x}) : (r_l >= lut_data);

    assign lut_addr = r_n;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= S_IDLE;
        end else if (srst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (enable) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt = w_range_err ? S_FINISH : S_ITER;
                    end
                end
                S_ITER: begin
                    if (r_n == c_n_last) begin
                        w_state_nxt = S_FINISH;
                    end
                end
                S_FINISH: w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == S_ITER) || (r_state == S_FINISH);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_e        <= '0;
            r_l        <= '0;
            r_x        <= '0;
            r_n        <= '0;
            r_mode     <= 1'b0;
            r_err_pend <= 1'b0;
            result     <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
        end else if (srst) begin
            r_e        <= '0;
            r_l        <= '0;
            r_x        <= '0;
            r_n        <= '0;
            r_mode     <= 1'b0;
            r_err_pend <= 1'b0;
            result     <= '0;
            err        <= 1'b0;
            done       <= 1'b0;
        end else if (enable) begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode     <= mode;
                        r_x        <= x_in;
                        r_n        <= '0;
                        r_e        <= c_one;
                        r_l        <= mode ? '0 : x_in;
                        r_err_pend <= w_range_err;
                    end
                end
                S_ITER: begin
                    if (w_d) begin
                        r_e <= w_s[W-1:0];
                        r_l <= r_mode ? (r_l + lut_data) : (r_l - lut_data);
                    end
                    if (r_n != c_n_last) begin
                        r_n <= r_n + 1'b1;
                    end
                end
                S_FINISH: begin
                    result <= r_err_pend ? '0 : (r_mode ? r_l : r_e);
                    err    <= r_err_pend;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_xfire_bkm_iter_core.sv
// ============================================================================
// Module   : tb_xfire_bkm_iter_core
// Brief    : Self-checking bench for xfire_bkm_iter_core against real-valued
//            exp/ln reference, with latency, control and reset scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xfire_bkm_iter_core;

    localparam int W     = 32;
    localparam int F     = 28;
    localparam int N     = 28;
    localparam int LOG2N = 5;
    localparam int TOL   = N + 2;
    localparam real c_scale = 268435456.0;

    logic             clk = 1'b0;
    logic             arst;
    logic             srst;
    logic             enable;
    logic             start;
    logic             mode;
    logic [W-1:0]     x_in;
    logic [LOG2N-1:0] lut_addr;
    logic [W-1:0]     lut_data;
    logic [W-1:0]     result;
    logic             err;
    logic             busy;
    logic             done;

    logic [W-1:0]     lut [0:(1<<LOG2N)-1];

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    assign lut_data = lut[lut_addr];

    xfire_bkm_iter_core #(.W(W), .F(F), .N(N), .LOG2N(LOG2N)) dut (
        .clk      (clk),
        .arst     (arst),
        .srst     (srst),
        .enable   (enable),
        .start    (start),
        .mode     (mode),
        .x_in     (x_in),
        .lut_addr (lut_addr),
        .lut_data (lut_data),
        .result   (result),
        .err      (err),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input longint got, input longint expv,
                         input longint tol = 0);
        longint diff;
        nchk++;
        diff = got - expv;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)", tag, got, expv, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint ref_exp(input longint x);
        return longint'($rtoi($exp(real'(x) / c_scale) * c_scale + 0.5));
    endfunction

    function automatic longint ref_ln(input longint x);
        return longint'($rtoi($ln(real'(x) / c_scale) * c_scale + 0.5));
    endfunction

    task automatic launch(input logic m, input logic [W-1:0] x);
        start = 1'b1;
        mode  = m;
        x_in  = x;
        tick();
        start = 1'b0;
    endtask

    // Counts cycles from the start-sampling edge until done is seen
    task automatic wait_done(input bit pulse, input int gap_at, output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            if (pulse && (cyc == 5 || cyc == 10)) begin
                start = 1'b1;
                mode  = 1'b1;
                x_in  = 32'h0800_0000;
            end else begin
                start = 1'b0;
            end
            enable = !(gap_at > 0 && cyc >= gap_at && cyc < gap_at + 7);
            tick();
            cyc++;
        end
        start  = 1'b0;
        enable = 1'b1;
        check("done_seen", longint'(done), 1);
    endtask

    initial begin
        int cyc;
        int ndone;
        logic [W-1:0] x;

        for (int n = 0; n < (1 << LOG2N); n++) begin
            lut[n] = W'($rtoi($ln(1.0 + $pow(2.0, -n)) * c_scale + 0.5));
        end

        arst = 1'b1; srst = 1'b0; enable = 1'b1; start = 1'b0; mode = 1'b0; x_in = '0;
        tick();
        tick();
        check("rst_result", longint'(result), 0);
        check("rst_err",    longint'(err),    0);
        check("rst_busy",   longint'(busy),   0);
        check("rst_done",   longint'(done),   0);
        check("rst_addr",   longint'(lut_addr), 0);
        arst = 1'b0;
        tick();

        // exp(0) = 1.0 exactly
        launch(1'b0, 32'h0000_0000);
        wait_done(1'b0, 0, cyc);
        check("e0_lat",    cyc, N + 1);
        check("e0_result", longint'(result), 64'h1000_0000);
        check("e0_err",    longint'(err), 0);

        // exp(ln2) with lut_addr sweeping 0..N-1 one per cycle
        launch(1'b0, 32'h0B17_217F);
        for (int k = 0; k < N; k++) begin
            check("sweep_addr", longint'(lut_addr), k);
            tick();
        end
        check("ln2_nodone", longint'(done), 0);
        tick();
        check("ln2_done",   longint'(done), 1);
        check("ln2_result", longint'(result), 64'h2000_0000, TOL);

        launch(1'b1, 32'h1000_0000);
        wait_done(1'b0, 0, cyc);
        check("l1_result", longint'(result), 0);
        check("l1_lat",    cyc, N + 1);

        launch(1'b1, 32'h2000_0000);
        wait_done(1'b0, 0, cyc);
        check("l2_result", longint'(result), 64'h0B17_217F, TOL);

        // ln of 0.5 is out of range
        launch(1'b1, 32'h0800_0000);
        check("lerr_busy",   longint'(busy), 1);
        check("lerr_nodone", longint'(done), 0);
        tick();
        check("lerr_done",   longint'(done), 1);
        check("lerr_err",    longint'(err), 1);
        check("lerr_result", longint'(result), 0);
        check("lerr_idle",   longint'(busy), 0);

        // start while busy is ignored
        launch(1'b0, 32'h0600_0000);
        wait_done(1'b1, 0, cyc);
        check("ign_lat",    cyc, N + 1);
        check("ign_result", longint'(result), ref_exp(64'h0600_0000), TOL);
        check("ign_err",    longint'(err), 0);
        tick();
        check("ign_pulse",  longint'(done), 0);
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done || busy) ndone++;
        end
        check("ign_requeue", ndone, 0);

        // enable low for 7 cycles mid-ITER
        launch(1'b1, 32'h3000_0000);
        wait_done(1'b0, 8, cyc);
        check("gap_lat",    cyc, N + 1 + 7);
        check("gap_result", longint'(result), ref_ln(64'h3000_0000), TOL);

        for (int t = 0; t < 12; t++) begin
            if (t % 2 == 0) begin
                x = W'($urandom_range(0, 322122547));
                launch(1'b0, x);
                wait_done(1'b0, 0, cyc);
                check("rnd_e_result", longint'(result), ref_exp(longint'(x)), TOL);
            end else begin
                x = W'($urandom_range(268435456, 1261646643));
                launch(1'b1, x);
                wait_done(1'b0, 0, cyc);
                check("rnd_l_result", longint'(result), ref_ln(longint'(x)), TOL);
            end
            check("rnd_lat", cyc, N + 1);
            check("rnd_err", longint'(err), 0);
        end

        // synchronous reset at iteration 12 aborts with no done
        launch(1'b0, 32'h1000_0000);
        repeat (12) tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check("srst_busy",   longint'(busy), 0);
        check("srst_done",   longint'(done), 0);
        check("srst_result", longint'(result), 0);
        check("srst_addr",   longint'(lut_addr), 0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done) ndone++;
        end
        check("srst_nodone", ndone, 0);

        // asynchronous reset during FINISH clears outputs at once
        launch(1'b0, 32'h0B17_217F);
        wait_done(1'b0, 0, cyc);
        launch(1'b0, 32'h0B17_217F);
        repeat (N) tick();
        check("fin_busy", longint'(busy), 1);
        arst = 1'b1;
        #1;
        check("arst_busy",   longint'(busy), 0);
        check("arst_result", longint'(result), 0);
        check("arst_done",   longint'(done), 0);
        check("arst_addr",   longint'(lut_addr), 0);
        #2;
        arst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

`default_nettype wire
